// File: rtl/riscv_package.sv
// Shared RV32 types, extended with the operation and state encodings
// used by the iterative divider.
package riscv_package;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  register_address_t;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } divide_operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divide_state_t;

    function automatic word_t negate(input word_t value);
        return ~value + 32'd1;
    endfunction

endpackage

// File: rtl/divide_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes, sign fixed up on the last step.
module divide_unit
    import riscv_package::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              start_valid,
    output logic              start_ready,
    input  divide_operation_t operation,
    input  word_t             dividend,
    input  word_t             divisor,
    input  register_address_t destination,
    output logic              result_valid,
    input  logic              result_ready,
    output word_t             result,
    output register_address_t result_destination
);

    divide_state_t     state, next_state;
    logic [4:0]        counter;
    logic              is_rem_q, negate_quotient, negate_remainder;
    word_t             divisor_q, quotient_q;
    logic [32:0]       partial_q;
    register_address_t destination_q;
    word_t             result_q;
    register_address_t result_destination_q;

    logic        accept, is_signed, is_rem, divide_by_zero, overflow, special;
    word_t       special_result, dividend_abs, divisor_abs;
    logic [32:0] shifted, difference, next_partial;
    logic        quotient_bit;
    word_t       next_quotient, final_quotient, final_remainder;

    // Request decode and special cases, resolved at the accept edge
    always_comb begin
        accept         = start_valid && start_ready && !flush;
        is_signed      = (operation == DIV) || (operation == REM);
        is_rem         = (operation == REM) || (operation == REMU);
        divide_by_zero = (divisor == 32'd0);
        overflow       = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        special        = divide_by_zero || overflow;
        if (divide_by_zero)
            special_result = is_rem ? dividend : 32'hFFFF_FFFF;
        else
            special_result = is_rem ? 32'd0 : 32'h8000_0000;
        dividend_abs = (is_signed && dividend[31]) ? negate(dividend) : dividend;
        divisor_abs  = (is_signed && divisor[31])  ? negate(divisor)  : divisor;
    end

    // The dividend shifts out of quotient_q MSB first as quotient bits shift in
    always_comb begin
        shifted         = {partial_q[31:0], quotient_q[31]};
        difference      = shifted - {1'b0, divisor_q};
        quotient_bit    = ~difference[32];
        next_partial    = quotient_bit ? difference : shifted;
        next_quotient   = {quotient_q[30:0], quotient_bit};
        final_quotient  = negate_quotient  ? negate(next_quotient)      : next_quotient;
        final_remainder = negate_remainder ? negate(next_partial[31:0]) : next_partial[31:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = special ? DONE : BUSY;
                BUSY:    if (counter == 5'd31) next_state = DONE;
                DONE:    if (result_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        start_ready        = (state == IDLE);
        result_valid       = (state == DONE);
        result             = result_q;
        result_destination = result_destination_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter              <= 5'd0;
            is_rem_q             <= 1'b0;
            negate_quotient      <= 1'b0;
            negate_remainder     <= 1'b0;
            divisor_q            <= 32'd0;
            quotient_q           <= 32'd0;
            partial_q            <= 33'd0;
            destination_q        <= 5'd0;
            result_q             <= 32'd0;
            result_destination_q <= 5'd0;
        end else if (flush) begin
            counter <= 5'd0;
        end else if (accept) begin
            counter          <= 5'd0;
            is_rem_q         <= is_rem;
            negate_quotient  <= is_signed && (dividend[31] ^ divisor[31]);
            negate_remainder <= is_signed && dividend[31];
            divisor_q        <= divisor_abs;
            quotient_q       <= dividend_abs;
            partial_q        <= 33'd0;
            destination_q    <= destination;
            if (special) begin
                result_q             <= special_result;
                result_destination_q <= destination;
            end
        end else if (state == BUSY) begin
            counter    <= counter + 5'd1;
            partial_q  <= next_partial;
            quotient_q <= next_quotient;
            if (counter == 5'd31) begin
                result_q             <= is_rem_q ? final_remainder : final_quotient;
                result_destination_q <= destination_q;
            end
        end
    end

endmodule

// File: tb/tb_divide_unit.sv
// Self-checking bench for divide_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_divide_unit;
    import riscv_package::*;

    logic              clk = 1'b0;
    logic              reset_n, flush, start_valid, start_ready;
    logic              result_valid, result_ready;
    divide_operation_t operation;
    word_t             dividend, divisor, result;
    register_address_t destination, result_destination;

    int testCount = 0;
    int failCount = 0;

    divide_unit dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .start_valid(start_valid), .start_ready(start_ready),
        .operation(operation), .dividend(dividend), .divisor(divisor),
        .destination(destination), .result_valid(result_valid),
        .result_ready(result_ready), .result(result),
        .result_destination(result_destination)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic isSignedOp(input divide_operation_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic isRemOp(input divide_operation_t op);
        return (op == REM) || (op == REMU);
    endfunction

    // RISC-V semantics: truncating division, with the fixed divide-by-zero answers
    function automatic word_t refModel(input divide_operation_t op, input word_t a, input word_t b);
        longint x, y, q, r;
        if (b == 32'd0) return isRemOp(op) ? a : 32'hFFFF_FFFF;
        if (isSignedOp(op)) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return isRemOp(op) ? r[31:0] : q[31:0];
    endfunction

    function automatic int refLatency(input divide_operation_t op, input word_t a, input word_t b);
        if (b == 32'd0) return 0;
        if (isSignedOp(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    task automatic applyStimulus(input divide_operation_t op, input word_t a, input word_t b,
                                 input register_address_t dest);
        int waited = 0;
        @(negedge clk);
        while (!start_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!start_ready) checkOutput("start_ready timeout", 32'(start_ready), 32'd1);
        operation   = op;
        dividend    = a;
        divisor     = b;
        destination = dest;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        dividend    = $urandom;
        divisor     = $urandom;
        destination = register_address_t'($urandom_range(0, 31));
    endtask

    // Counts clock edges after the accept edge until result_valid is seen
    task automatic waitResult(output int edges);
        edges = 0;
        while (!result_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!result_valid) checkOutput("result_valid timeout", 32'(result_valid), 32'd1);
    endtask

    task automatic runOp(input string tag, input divide_operation_t op, input word_t a,
                         input word_t b, input register_address_t dest);
        int lat;
        applyStimulus(op, a, b, dest);
        waitResult(lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'(refLatency(op, a, b)));
        checkOutput({tag, " result"}, result, refModel(op, a, b));
        checkOutput({tag, " destination"}, 32'(result_destination), 32'(dest));
        @(posedge clk);
        #1;
        checkOutput({tag, " valid width"}, 32'(result_valid), 32'd0);
        checkOutput({tag, " ready after"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        word_t savedResult;
        register_address_t savedDest;
        logic stable, sawValid;
        int lat;

        reset_n      = 1'b0;
        flush        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b1;
        operation    = DIVU;
        dividend     = 32'd0;
        divisor      = 32'd0;
        destination  = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset start_ready", 32'(start_ready), 32'd1);
        checkOutput("reset result_valid", 32'(result_valid), 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset destination", 32'(result_destination), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        runOp("divu 100/7", DIVU, 32'd100, 32'd7, 5'd3);
        checkOutput("divu 100/7 const", result, 32'd14);
        runOp("remu 100/7", REMU, 32'd100, 32'd7, 5'd4);
        runOp("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
        runOp("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
        runOp("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 5'd7);
        runOp("div min/2", DIV, 32'h8000_0000, 32'd2, 5'd8);
        runOp("div 5/0", DIV, 32'd5, 32'd0, 5'd9);
        runOp("remu 5/0", REMU, 32'd5, 32'd0, 5'd10);
        runOp("div overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        runOp("rem overflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        runOp("divu min/-1", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        runOp("rd zero", DIVU, 32'd77, 32'd5, 5'd0);

        // Backpressure: result must hold while writeback stalls
        result_ready = 1'b0;
        applyStimulus(REM, 32'hFFFF_FF9C, 32'd7, 5'd21);
        waitResult(lat);
        savedResult = result;
        savedDest   = result_destination;
        checkOutput("stall result", savedResult, refModel(REM, 32'hFFFF_FF9C, 32'd7));
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!result_valid || start_ready || result !== savedResult || result_destination !== savedDest)
                stable = 1'b0;
        end
        checkOutput("stall hold", 32'(stable), 32'd1);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("stall release ready", 32'(start_ready), 32'd1);
        checkOutput("stall release valid", 32'(result_valid), 32'd0);

        // Flush while counter==10, with a competing request in the same cycle
        applyStimulus(DIVU, 32'd1000, 32'd3, 5'd14);
        repeat (10) @(posedge clk);
        #1;
        flush       = 1'b1;
        start_valid = 1'b1;
        operation   = DIVU;
        dividend    = 32'd50;
        divisor     = 32'd5;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        start_valid = 1'b0;
        checkOutput("flush ready", 32'(start_ready), 32'd1);
        sawValid = 1'b0;
        repeat (40) begin
            if (result_valid || !start_ready) sawValid = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("flush no result", 32'(sawValid), 32'd0);
        runOp("divu 9/3", DIVU, 32'd9, 32'd3, 5'd15);

        // Asynchronous reset between edges while busy
        applyStimulus(DIVU, 32'd12345, 32'd11, 5'd16);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset ready", 32'(start_ready), 32'd1);
        checkOutput("async reset valid", 32'(result_valid), 32'd0);
        checkOutput("async reset result", result, 32'd0);
        checkOutput("async reset destination", 32'(result_destination), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        runOp("divu max/1", DIVU, 32'hFFFF_FFFF, 32'd1, 5'd17);
        runOp("remu max/1", REMU, 32'hFFFF_FFFF, 32'd1, 5'd18);

        for (int i = 0; i < 40; i++) begin
            divide_operation_t op;
            word_t a, b;
            op = divide_operation_t'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : word_t'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = word_t'($urandom_range(1, 20));
                default: b = word_t'($urandom);
            endcase
            runOp($sformatf("random %0d", i), op, a, b, register_address_t'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
